// File: rtl/qdr_port_arbiter.sv
// Shares one QDR controller read/write interface among NUM_PORTS requesters with
// independent round-robin read and write arbitration and in-order read-data steering.
module qdr_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_BITS  = 18,
  parameter int DATA_WIDTH = 144,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                            clk_ctl,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_rd_req,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]  port_rd_addr,
  output logic [NUM_PORTS-1:0]            port_rd_ack,
  output logic [NUM_PORTS-1:0]            port_rd_valid,
  output logic [DATA_WIDTH-1:0]           port_rd_data,
  input  logic [NUM_PORTS-1:0]            port_wr_req,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]  port_wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_data,
  output logic [NUM_PORTS-1:0]            port_wr_ack,
  output logic                            ctl_rd_en,
  output logic [ADDR_BITS-1:0]            ctl_rd_addr,
  input  logic                            ctl_rd_valid,
  input  logic [DATA_WIDTH-1:0]           ctl_rd_data,
  output logic                            ctl_wr_en,
  output logic [ADDR_BITS-1:0]            ctl_wr_addr,
  output logic [DATA_WIDTH-1:0]           ctl_wr_data,
  output logic [$clog2(TAG_DEPTH):0]      rd_outstanding,
  output logic                            err_underflow
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TAG_DEPTH);

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic [PW:0]   res;
    logic [PW-1:0] sel;
    res = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel = PW'((int'(ptr) + i) % NUM_PORTS);
      if (!res[PW] && req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   rd_pick, wr_pick;
  logic [PW-1:0] rd_idx, wr_idx;
  logic          rd_grant, wr_grant, rd_empty, rd_pop;
  logic [PW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] tag_wptr, tag_rptr;

  // Handshake: a port holds req (and its addr/data) until it sees ack in the
  // same cycle; req & ack is the single transfer cycle, ack never waits on a register.
  always_comb begin
    rd_pick     = rr_pick(port_rd_req, rd_ptr);
    wr_pick     = rr_pick(port_wr_req, wr_ptr);
    rd_idx      = rd_pick[PW-1:0];
    wr_idx      = wr_pick[PW-1:0];
    rd_grant    = rst_n && rd_pick[PW] && (rd_outstanding != FULL_CNT);
    wr_grant    = rst_n && wr_pick[PW];
    port_rd_ack = rd_grant ? (NUM_PORTS'(1) << rd_idx) : '0;
    port_wr_ack = wr_grant ? (NUM_PORTS'(1) << wr_idx) : '0;
    rd_empty    = (rd_outstanding == '0);
    rd_pop      = ctl_rd_valid && !rd_empty;
  end

  always_ff @(posedge clk_ctl or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      tag_wptr       <= '0;
      tag_rptr       <= '0;
      rd_outstanding <= '0;
      ctl_rd_en      <= 1'b0;
      ctl_rd_addr    <= '0;
      ctl_wr_en      <= 1'b0;
      ctl_wr_addr    <= '0;
      ctl_wr_data    <= '0;
      port_rd_valid  <= '0;
      port_rd_data   <= '0;
      err_underflow  <= 1'b0;
    end else begin
      ctl_rd_en   <= rd_grant;
      ctl_rd_addr <= rd_grant ? port_rd_addr[rd_idx*ADDR_BITS +: ADDR_BITS] : '0;
      ctl_wr_en   <= wr_grant;
      ctl_wr_addr <= wr_grant ? port_wr_addr[wr_idx*ADDR_BITS +: ADDR_BITS] : '0;
      ctl_wr_data <= wr_grant ? port_wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (rd_grant) begin
        rd_ptr   <= next_ptr(rd_idx);
        tag_wptr <= tag_wptr + 1'b1;
      end
      if (wr_grant) wr_ptr <= next_ptr(wr_idx);
      if (rd_pop) begin
        tag_rptr     <= tag_rptr + 1'b1;
        port_rd_data <= ctl_rd_data;
      end
      port_rd_valid  <= rd_pop ? (NUM_PORTS'(1) << tag_mem[tag_rptr]) : '0;
      rd_outstanding <= rd_outstanding + (AW+1)'(rd_grant) - (AW+1)'(rd_pop);
      // A return with no tag recorded is a protocol error; the FIFO is left alone.
      if (ctl_rd_valid && rd_empty) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_ctl) begin
    if (rd_grant) tag_mem[tag_wptr] <= rd_idx;
  end

endmodule

// File: doc/qdr_port_arbiter.md
Name: qdr_port_arbiter

Overview:
Shares one QDR2PController user interface among NUM_PORTS requesters, such as packet buffer writers, lookup engines and a host bridge. Read and write channels are arbitrated independently, each by its own round-robin pointer. The block records which port issued each read in an in-order tag FIFO and steers returned read data back to that port. It sits in the clk_ctl domain between the requester logic and the controller's rd_*/wr_* ports.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_BITS, 18, address width, matches controller
DATA_WIDTH, 144, burst data width (4 x 36-bit beats)
TAG_DEPTH, 16, max outstanding reads; power of 2, at least the controller read latency in cycles

Ports:
clk_ctl  in  1  controller-side clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
port_rd_req  in  NUM_PORTS  per-port read request, held until acked
port_rd_addr  in  NUM_PORTS*ADDR_BITS  per-port read address; port i at [i*ADDR_BITS +: ADDR_BITS]
port_rd_ack  out  NUM_PORTS  combinational one-hot grant; transfer occurs when req&ack
port_rd_valid  out  NUM_PORTS  one-hot, read data valid for that port
port_rd_data  out  DATA_WIDTH  returned burst, shared by all ports
port_wr_req  in  NUM_PORTS  per-port write request
port_wr_addr  in  NUM_PORTS*ADDR_BITS  per-port write address
port_wr_data  in  NUM_PORTS*DATA_WIDTH  per-port write burst
port_wr_ack  out  NUM_PORTS  combinational one-hot write grant
ctl_rd_en  out  1  to controller rd_en
ctl_rd_addr  out  ADDR_BITS  to controller rd_addr
ctl_rd_valid  in  1  from controller rd_valid
ctl_rd_data  in  DATA_WIDTH  from controller rd_data
ctl_wr_en  out  1  to controller wr_en
ctl_wr_addr  out  ADDR_BITS  to controller wr_addr
ctl_wr_data  out  DATA_WIDTH  to controller wr_data
rd_outstanding  out  $clog2(TAG_DEPTH)+1  reads issued but not yet returned
err_underflow  out  1  sticky; ctl_rd_valid seen while the tag FIFO was empty

Behaviour:
- Reset: all outputs 0, both RR pointers 0, tag FIFO empty, err_underflow 0. Reset takes effect immediately and asynchronously; release is synchronous to clk_ctl.
- Read arbitration, same cycle:
  - Search starts at rd_ptr and wraps mod NUM_PORTS; the first port with port_rd_req set is granted.
  - The grant is blocked when rd_outstanding == TAG_DEPTH. A pop in the same cycle does not unblock it.
  - At most one port_rd_ack bit is set per cycle.
- Read issue: the cycle after a grant, ctl_rd_en=1 for exactly one cycle, with ctl_rd_addr set to the granted port's address. Otherwise ctl_rd_en=0 and ctl_rd_addr=0.
- Tag push: the granted port index is pushed on the grant cycle. rd_ptr becomes (granted+1) mod NUM_PORTS. With no grant, rd_ptr holds.
- Read return:
  - When ctl_rd_valid=1, the FIFO head is popped.
  - The next cycle, port_rd_valid[head]=1 for one cycle and port_rd_data holds the registered ctl_rd_data.
  - Otherwise port_rd_valid=0 and port_rd_data holds its last value.
- Return with FIFO empty: set err_underflow, assert no port_rd_valid, leave the FIFO untouched.
- Simultaneous push and pop: both take effect, and rd_outstanding is unchanged.
- Write channel:
  - Uses the same RR scheme with its own wr_ptr and no capacity limit.
  - The cycle after a grant, ctl_wr_en=1 with the granted address and data. Otherwise ctl_wr_en=0 and ctl_wr_addr/ctl_wr_data=0.
- The read and write channels may both grant in the same cycle, to the same or to different ports.
- Ordering: reads return in issue order, because the controller has fixed latency. No read/write hazard ordering is provided; a port needing read-after-write waits for its wr_ack before requesting the read.
- Reset mid-operation: outstanding tags are discarded. Returns that arrive later set err_underflow, which the bench must expect.
- FIFO pointers wrap mod TAG_DEPTH. The count is one bit wider than the pointers, to tell full from empty.

Test Plan:
- Single port: port 0 writes 0x0beef with data A; after wr_ack, port 0 reads 0x0beef -> ctl_wr_en 1 cycle after ack; read returns A on port_rd_valid=4'b0001 only.
- All 4 ports hold port_rd_req for 8 cycles with distinct addresses -> grants in order 0,1,2,3,0,1,2,3; each port receives its own data, in order.
- Ports 1 and 3 request, rd_ptr=2 -> port 3 granted first, then port 1; rd_ptr ends at 2.
- Controller rd_valid held off until 16 reads are outstanding -> rd_outstanding=16, no further ack; the first return re-enables the grant on the following cycle.
- Same cycle: port 2 write grant and port 0 read grant -> ctl_wr_en and ctl_rd_en both high in the next cycle with the correct addresses.
- Inject ctl_rd_valid with nothing outstanding, and separately pulse rst_n low with 3 reads in flight -> err_underflow=1, no port_rd_valid, all other outputs 0 during reset.
